// File: rtl/jtcontra_rom_pkg.sv
// Shared types and helpers for the Contra ROM slot responders.
package jtcontra_rom_pkg;

  localparam int SDRAM_AW = 22;
  localparam int SDRAM_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT
  } slot_state_e;

  // Lanes count upwards from the low end of the fetched word.
  function automatic logic [15:0] lane_sel(input logic [SDRAM_DW-1:0] word,
                                           input logic [1:0]          lane,
                                           input logic                wide);
    if (wide) return lane[0] ? word[31:16] : word[15:0];
    return {8'h00, word[8*lane +: 8]};
  endfunction

endpackage

// File: rtl/jtcontra_rom_slot_if.sv
// SDRAM controller side of a ROM slot: req/ack request, rdy data strobe.
interface jtcontra_rom_slot_if;
  import jtcontra_rom_pkg::*;

  logic                sdram_req;
  logic [SDRAM_AW-1:0] sdram_addr;
  logic                sdram_ack;
  logic                sdram_rdy;
  logic [SDRAM_DW-1:0] sdram_data;

  modport master (
    output sdram_req, sdram_addr,
    input  sdram_ack, sdram_rdy, sdram_data
  );

  modport slave (
    input  sdram_req, sdram_addr,
    output sdram_ack, sdram_rdy, sdram_data
  );

endinterface

// File: rtl/jtcontra_rom_cache2.sv
// Two-entry tag/word cache with LRU replacement; one lookup port, one fill port.
module jtcontra_rom_cache2 import jtcontra_rom_pkg::*; #(
  parameter int TW = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic [TW-1:0]       lookup_tag,
  input  logic                touch,
  input  logic                fill_en,
  input  logic [TW-1:0]       fill_tag,
  input  logic [SDRAM_DW-1:0] fill_word,
  output logic                hit,
  output logic [SDRAM_DW-1:0] hit_word
);

  logic [TW-1:0]       tag_q  [2];
  logic [TW-1:0]       tag_d  [2];
  logic [SDRAM_DW-1:0] word_q [2];
  logic [SDRAM_DW-1:0] word_d [2];
  logic [1:0]          valid_q, valid_d;
  logic                lru_q, lru_d;
  logic [1:0]          match;

  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      match[i] = valid_q[i] && (tag_q[i] == lookup_tag);
    end
  end

  assign hit      = |match;
  assign hit_word = match[1] ? word_q[1] : word_q[0];

  // A fill owns the LRU pointer over a same-cycle touch; clear wins over fill.
  always_comb begin
    tag_d   = tag_q;
    word_d  = word_q;
    valid_d = valid_q;
    lru_d   = lru_q;
    if (touch) lru_d = ~match[1];
    if (fill_en) begin
      tag_d[lru_q]   = fill_tag;
      word_d[lru_q]  = fill_word;
      valid_d[lru_q] = 1'b1;
      lru_d          = ~lru_q;
    end
    if (clear) valid_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q   <= '{default: '0};
      word_q  <= '{default: '0};
      valid_q <= '0;
      lru_q   <= 1'b0;
    end else begin
      tag_q   <= tag_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      lru_q   <= lru_d;
    end
  end

endmodule

// File: rtl/jtcontra_rom_slot.sv
// SDRAM-side responder for one Contra game ROM port, backed by a 2-word cache.
module jtcontra_rom_slot import jtcontra_rom_pkg::*; #(
  parameter int                  AW     = 17,
  parameter int                  DW     = 8,
  parameter logic [SDRAM_AW-1:0] OFFSET = 22'h0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          downloading,
  input  logic          rom_cs,
  input  logic [AW-1:0] rom_addr,
  output logic [DW-1:0] rom_data,
  output logic          rom_ok,
  jtcontra_rom_slot_if.master sdram
);

  localparam int TW = (DW == 16) ? AW - 1 : AW - 2;

  slot_state_e         state_q, state_d;
  logic                req_q, req_d;
  logic [SDRAM_AW-1:0] saddr_q, saddr_d;
  logic [TW-1:0]       fetch_tag_q, fetch_tag_d;
  logic                discard_q, discard_d;
  logic [DW-1:0]       data_q, data_d;
  logic [AW-1:0]       addr_l_q, addr_l_d;
  logic                ok_l_q, ok_l_d;

  logic [TW-1:0]       tag;
  logic [1:0]          lane;
  logic                hit, touch, fill_en;
  logic [SDRAM_DW-1:0] hit_word;

  assign tag   = rom_addr[AW-1:AW-TW];
  assign lane  = (DW == 16) ? {1'b0, rom_addr[0]} : rom_addr[1:0];
  assign touch = rom_cs & hit & ~downloading;

  jtcontra_rom_cache2 #(.TW(TW)) u_cache (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (downloading),
    .lookup_tag (tag),
    .touch      (touch),
    .fill_en    (fill_en),
    .fill_tag   (fetch_tag_q),
    .fill_word  (sdram.sdram_data),
    .hit        (hit),
    .hit_word   (hit_word)
  );

  // discard remembers a download seen at any point of an in-flight fetch,
  // so a word fetched before the new ROM image never reaches the cache.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    saddr_d     = saddr_q;
    fetch_tag_d = fetch_tag_q;
    discard_d   = discard_q | downloading;
    fill_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        discard_d = 1'b0;
        if (rom_cs && !hit && !downloading) begin
          fetch_tag_d = tag;
          saddr_d     = OFFSET + SDRAM_AW'({tag, 1'b0});
          req_d       = 1'b1;
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        if (sdram.sdram_ack) begin
          req_d = 1'b0;
          if (sdram.sdram_rdy) begin
            fill_en = ~discard_d;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (sdram.sdram_rdy) begin
          fill_en = ~discard_d;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    data_d   = data_q;
    addr_l_d = addr_l_q;
    ok_l_d   = ok_l_q;
    if (downloading) begin
      ok_l_d = 1'b0;
    end else if (touch) begin
      data_d   = DW'(lane_sel(hit_word, lane, DW == 16));
      addr_l_d = rom_addr;
      ok_l_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_q       <= 1'b0;
      saddr_q     <= '0;
      fetch_tag_q <= '0;
      discard_q   <= 1'b0;
      data_q      <= '0;
      addr_l_q    <= '0;
      ok_l_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      saddr_q     <= saddr_d;
      fetch_tag_q <= fetch_tag_d;
      discard_q   <= discard_d;
      data_q      <= data_d;
      addr_l_q    <= addr_l_d;
      ok_l_q      <= ok_l_d;
    end
  end

  assign sdram.sdram_req  = req_q;
  assign sdram.sdram_addr = saddr_q;
  assign rom_data         = data_q;
  assign rom_ok           = ok_l_q & rom_cs & (rom_addr == addr_l_q);

endmodule

// File: tb/tb_jtcontra_rom_slot.sv
// Bench for jtcontra_rom_slot: a DW=8 slot and a DW=16 slot with an SDRAM offset.
module tb_jtcontra_rom_slot;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        dl8 = 1'b0, cs8 = 1'b0, rom_ok8;
  logic [16:0] addr8 = '0;
  logic [7:0]  rom_data8;
  logic        dl16 = 1'b0, cs16 = 1'b0, rom_ok16;
  logic [16:0] addr16 = '0;
  logic [15:0] rom_data16;

  jtcontra_rom_slot_if bus8();
  jtcontra_rom_slot_if bus16();

  jtcontra_rom_slot #(.AW(17), .DW(8), .OFFSET(22'h0)) u8 (
    .clk(clk), .rst_n(rst_n), .downloading(dl8), .rom_cs(cs8), .rom_addr(addr8),
    .rom_data(rom_data8), .rom_ok(rom_ok8), .sdram(bus8)
  );

  jtcontra_rom_slot #(.AW(17), .DW(16), .OFFSET(22'h100)) u16 (
    .clk(clk), .rst_n(rst_n), .downloading(dl16), .rom_cs(cs16), .rom_addr(addr16),
    .rom_data(rom_data16), .rom_ok(rom_ok16), .sdram(bus16)
  );

  logic [21:0] exp8_q[$];
  logic [21:0] exp16_q[$];
  bit prev8 = 1'b0, prev16 = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every new request must match the next address the stimulus announced.
  always @(negedge clk) begin
    if (bus8.sdram_req && !prev8) begin
      if (exp8_q.size() == 0) check("req8_spurious", {31'b0, bus8.sdram_req}, 32'd0);
      else check("req8_addr", {10'b0, bus8.sdram_addr}, {10'b0, exp8_q.pop_front()});
    end
    if (bus16.sdram_req && !prev16) begin
      if (exp16_q.size() == 0) check("req16_spurious", {31'b0, bus16.sdram_req}, 32'd0);
      else check("req16_addr", {10'b0, bus16.sdram_addr}, {10'b0, exp16_q.pop_front()});
    end
    prev8  = bus8.sdram_req;
    prev16 = bus16.sdram_req;
  end

  task automatic fetch8(input logic [31:0] w);
    int n = 0;
    while (!bus8.sdram_req && n < 20) begin step(); n++; end
    check("fetch8_req", {31'b0, bus8.sdram_req}, 32'd1);
    bus8.sdram_ack = 1'b1; step(); bus8.sdram_ack = 1'b0;
    check("fetch8_ack_drop", {31'b0, bus8.sdram_req}, 32'd0);
    bus8.sdram_rdy = 1'b1; bus8.sdram_data = w; step(); bus8.sdram_rdy = 1'b0;
  endtask

  task automatic fetch16(input logic [31:0] w, input bit same_cycle);
    int n = 0;
    while (!bus16.sdram_req && n < 20) begin step(); n++; end
    check("fetch16_req", {31'b0, bus16.sdram_req}, 32'd1);
    bus16.sdram_ack = 1'b1;
    if (!same_cycle) begin step(); bus16.sdram_ack = 1'b0; end
    bus16.sdram_rdy = 1'b1; bus16.sdram_data = w; step();
    bus16.sdram_rdy = 1'b0; bus16.sdram_ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    bus8.sdram_ack = 1'b0; bus8.sdram_rdy = 1'b0; bus8.sdram_data = '0;
    bus16.sdram_ack = 1'b0; bus16.sdram_rdy = 1'b0; bus16.sdram_data = '0;

    // Reset values
    #12;
    check("rst_ok8", {31'b0, rom_ok8}, 32'd0);
    check("rst_data8", {24'b0, rom_data8}, 32'd0);
    check("rst_req8", {31'b0, bus8.sdram_req}, 32'd0);
    check("rst_addr8", {10'b0, bus8.sdram_addr}, 32'd0);
    check("rst_req16", {31'b0, bus16.sdram_req}, 32'd0);
    check("rst_data16", {16'b0, rom_data16}, 32'd0);
    step(); rst_n = 1'b1; step();

    // Cold miss, DW=8
    cs8 = 1'b1; addr8 = 17'h00005; exp8_q.push_back(22'h000002);
    fetch8(32'hDDCC_BBAA);
    check("cold_ok_fill_edge", {31'b0, rom_ok8}, 32'd0);
    step();
    check("cold_ok", {31'b0, rom_ok8}, 32'd1);
    check("cold_data", {24'b0, rom_data8}, 32'h0000_00BB);

    // Sequential hits without SDRAM traffic
    w = 32'hDDCC_BBAA;
    for (int i = 0; i < 4; i++) begin
      addr8 = 17'(4 + i); #1;
      check("seq_ok_drop", {31'b0, rom_ok8}, 32'd0);
      step();
      check("seq_ok", {31'b0, rom_ok8}, 32'd1);
      check("seq_data", {24'b0, rom_data8}, {24'b0, w[8*i +: 8]});
    end

    // Address abandoned while the fetch is in WAIT
    addr8 = 17'h100; exp8_q.push_back(22'h000080);
    step(); check("ab_req1", {31'b0, bus8.sdram_req}, 32'd1);
    step();
    bus8.sdram_ack = 1'b1; step(); bus8.sdram_ack = 1'b0;
    addr8 = 17'h200; exp8_q.push_back(22'h000100);
    step(); check("ab_wait_ok", {31'b0, rom_ok8}, 32'd0);
    bus8.sdram_rdy = 1'b1; bus8.sdram_data = 32'h1122_3344; step(); bus8.sdram_rdy = 1'b0;
    check("ab_fill_ok", {31'b0, rom_ok8}, 32'd0);
    step();
    check("ab_req2", {31'b0, bus8.sdram_req}, 32'd1);
    check("ab_req2_ok", {31'b0, rom_ok8}, 32'd0);
    bus8.sdram_ack = 1'b1; step(); bus8.sdram_ack = 1'b0;
    bus8.sdram_rdy = 1'b1; bus8.sdram_data = 32'h5566_7788; step(); bus8.sdram_rdy = 1'b0;
    check("ab_ok_early", {31'b0, rom_ok8}, 32'd0);
    step();
    check("ab_ok", {31'b0, rom_ok8}, 32'd1);
    check("ab_data", {24'b0, rom_data8}, 32'h0000_0088);
    addr8 = 17'h103; step();
    check("ab_stale_fill_ok", {31'b0, rom_ok8}, 32'd1);
    check("ab_stale_fill_data", {24'b0, rom_data8}, 32'h0000_0011);

    // Download invalidates and blocks fetches
    dl8 = 1'b1; step();
    check("dl_ok", {31'b0, rom_ok8}, 32'd0);
    step(); step();
    check("dl_no_req", {31'b0, bus8.sdram_req}, 32'd0);
    exp8_q.push_back(22'h000080);
    dl8 = 1'b0; step();
    check("dl_refetch", {31'b0, bus8.sdram_req}, 32'd1);
    fetch8(32'hA5A5_5A5A); step();
    check("dl_ok_after", {31'b0, rom_ok8}, 32'd1);
    check("dl_data_after", {24'b0, rom_data8}, 32'h0000_00A5);

    // LRU, DW=16 with offset
    cs16 = 1'b1; addr16 = 17'd0; exp16_q.push_back(22'h100);
    fetch16(32'hB1B0_A1A0, 1'b0);
    check("lru_a_fill_edge", {31'b0, rom_ok16}, 32'd0);
    step();
    check("lru_a_ok", {31'b0, rom_ok16}, 32'd1);
    check("lru_a_data", {16'b0, rom_data16}, 32'h0000_A1A0);
    addr16 = 17'd16; exp16_q.push_back(22'h110);
    fetch16(32'h2222_1111, 1'b0); step();
    check("lru_b_data", {16'b0, rom_data16}, 32'h0000_1111);
    addr16 = 17'd1; step();
    check("lru_a_hi_ok", {31'b0, rom_ok16}, 32'd1);
    check("lru_a_hi_data", {16'b0, rom_data16}, 32'h0000_B1B0);
    addr16 = 17'd32; exp16_q.push_back(22'h120);
    fetch16(32'h3333_CCCC, 1'b1); step();
    check("lru_c_ackrdy_ok", {31'b0, rom_ok16}, 32'd1);
    check("lru_c_data", {16'b0, rom_data16}, 32'h0000_CCCC);
    addr16 = 17'd0; step();
    check("lru_a_kept_ok", {31'b0, rom_ok16}, 32'd1);
    check("lru_a_kept_noreq", {31'b0, bus16.sdram_req}, 32'd0);
    check("lru_a_kept_data", {16'b0, rom_data16}, 32'h0000_A1A0);
    addr16 = 17'd16; exp16_q.push_back(22'h110);
    step();
    check("lru_b_evicted", {31'b0, bus16.sdram_req}, 32'd1);
    fetch16(32'h2222_1111, 1'b0); step();
    check("lru_b_refill", {16'b0, rom_data16}, 32'h0000_1111);

    // Asynchronous reset during REQ
    addr8 = 17'h200; exp8_q.push_back(22'h000100);
    step(); check("ar_req", {31'b0, bus8.sdram_req}, 32'd1);
    step();
    rst_n = 1'b0; #1;
    check("ar_req_drop", {31'b0, bus8.sdram_req}, 32'd0);
    check("ar_ok", {31'b0, rom_ok8}, 32'd0);
    cs8 = 1'b0; cs16 = 1'b0;
    step(); step(); rst_n = 1'b1; step();
    bus8.sdram_rdy = 1'b1; bus8.sdram_data = 32'hFFFF_FFFF; step(); bus8.sdram_rdy = 1'b0;
    step();
    cs8 = 1'b1; #1;
    check("ar_ok_after", {31'b0, rom_ok8}, 32'd0);
    exp8_q.push_back(22'h000100);
    step();
    check("ar_first_miss", {31'b0, bus8.sdram_req}, 32'd1);
    fetch8(32'h0000_00C3); step();
    check("ar_ok_final", {31'b0, rom_ok8}, 32'd1);
    check("ar_data_final", {24'b0, rom_data8}, 32'h0000_00C3);

    step(); step();
    check("req8_all_seen", exp8_q.size(), 32'd0);
    check("req16_all_seen", exp16_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
